// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: one digit per cycle, LSD first.
// Define BCD_SUB_ABS_EN to report |a - b| with borrow_out as the sign.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow_out,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

`ifdef BCD_SUB_ABS_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          br_q, br_d;
  logic          werr_q, werr_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bo_q, bo_d;
  logic          err_q, err_d;

  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic [4:0]    t5;
  logic          dig_neg;
  logic [3:0]    dig;
  logic          bad;
  logic [W-1:0]  res_sh;

  // One BCD digit step; NEG pass reuses it as 0 - result digit.
  always_comb begin
    op_a = 4'd0;
    op_b = res_q[3:0];
    if (state_q == SUB) begin
      op_a = a_q[3:0];
      op_b = b_q[3:0];
    end
    t5      = {1'b0, op_a} - {1'b0, op_b} - {4'd0, br_q};
    dig_neg = t5[4];
    dig     = dig_neg ? (t5[3:0] + 4'd10) : t5[3:0];
    bad     = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
    res_sh  = (res_q >> 4) | (W'(dig) << (W - 4));
  end

  // Next-state logic: operand latch, digit sequencing, result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    br_d    = br_q;
    werr_d  = werr_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          idx_d   = '0;
          br_d    = 1'b0;
          werr_d  = 1'b0;
          state_d = SUB;
        end
      end
      SUB: begin
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        res_d  = res_sh;
        br_d   = dig_neg;
        werr_d = werr_q | bad;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef BCD_SUB_ABS_EN
          if (dig_neg) begin
            br_d    = 1'b0;
            state_d = NEG;
          end else begin
            diff_d  = res_sh;
            bo_d    = 1'b0;
            err_d   = werr_q | bad;
            state_d = DONE;
          end
`else
          diff_d  = res_sh;
          bo_d    = dig_neg;
          err_d   = werr_q | bad;
          state_d = DONE;
`endif
        end
      end
`ifdef BCD_SUB_ABS_EN
      NEG: begin
        res_d = res_sh;
        br_d  = dig_neg;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          diff_d  = res_sh;
          bo_d    = 1'b1;
          err_d   = werr_q;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      br_q    <= 1'b0;
      werr_q  <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      br_q    <= br_d;
      werr_q  <= werr_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4).
// Expectations follow BCD_SUB_ABS_EN when it is defined.
module tb_bcd_serial_subtractor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow_out;
  logic        err;

  int total;
  int passed;
  logic [15:0] last_diff;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        bo;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; drives a start and follows the operation.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] ed, input logic eb,
                       input logic ee, input int elat);
    int   n;
    logic busy_ok;
    logic hold_ok;
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (diff !== last_diff) hold_ok = 1'b0;
      a = ~a;
      b = ~b;
      @(negedge clk);
      n++;
    end
    chk("latency", n, elat);
    chk("busy_during_op", {busy_ok, busy}, 2'b11);
    chk("result_held", hold_ok, 1'b1);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("err", err, ee);
    @(negedge clk);
    chk("done_single", {busy, done}, 2'b00);
    last_diff = ed;
  endtask

  initial begin
    int n;
    int dcount;
    total = 0;
    passed = 0;
    last_diff = 16'h0000;

    vt[0] = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5};
    vt[1] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5};
`ifdef BCD_SUB_ABS_EN
    vt[2] = '{16'h0123, 16'h0456, 16'h0333, 1'b1, 1'b0, 9};
`else
    vt[2] = '{16'h0123, 16'h0456, 16'h9667, 1'b1, 1'b0, 5};
`endif
    vt[3] = '{16'h00A0, 16'h0001, 16'h0099, 1'b0, 1'b1, 5};
    vt[4] = '{16'h0009, 16'h0009, 16'h0000, 1'b0, 1'b0, 5};
    vt[5] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5};
`ifdef BCD_SUB_ABS_EN
    vt[6] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
`else
    vt[6] = '{16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0, 5};
`endif
    vt[7] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5};
    vt[8] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, 5};

    rst = 1'b1;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {busy, done, diff, borrow_out, err}, 20'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].d, vt[i].bo, vt[i].er, vt[i].lat);
    end

    // start mid-operation and on the done cycle must be ignored
    a = 16'h5432;
    b = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    dcount = 0;
    while (!done && n < 40) begin
      if (n == 2) begin
        start = 1'b1;
        a = 16'h1111;
        b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("ign_latency", n, 5);
    chk("ign_diff", diff, 16'h4198);
    start = 1'b1;
    a = 16'h2222;
    b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", {busy, done}, 2'b00);
    repeat (8) begin
      if (done) dcount++;
      a = a + 16'h1;
      @(negedge clk);
    end
    chk("no_second_done", dcount, 0);
    chk("idle_hold", {diff, borrow_out, err}, {16'h4198, 2'b00});
    last_diff = 16'h4198;

    // reset during the second SUB cycle aborts the operation
    a = 16'h0123;
    b = 16'h0456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs",
        {busy, done, diff, borrow_out, err}, 20'h0);
    start = 1'b1;
    @(negedge clk);
    chk("reset_over_start", {busy, done}, 2'b00);
    rst = 1'b0;
    last_diff = 16'h0000;
    do_op(16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
